// File: rtl/vga_color_pkg.sv
// vga_color_pkg: default palette contents and helpers shared by the colour LUT.
package vga_color_pkg;
  localparam int MAX_RGB_W = 96;
  localparam int COL_BG = 0;
  localparam int COL_BLACK = 1;
  localparam int COL_CYAN = 2;
  localparam int COL_CREAM = 3;
  localparam int COL_BROWN = 4;
  localparam int COL_GREEN = 5;
  localparam int COL_WHITE = 6;
  localparam logic [23:0] DEFAULT_PALETTE [8] = '{
    24'hAAAAAA, 24'h000000, 24'h00FFFF, 24'hFFE4B5,
    24'hD2B48C, 24'h00FF00, 24'hFFFFFF, 24'hAAAAAA
  };
  // Each 8-bit channel is left-aligned into RGB_W/3 bits (truncated or zero-padded).
  function automatic logic [MAX_RGB_W-1:0] default_rgb(input int idx, input int rgb_w);
    logic [23:0] c24;
    logic [MAX_RGB_W-1:0] v;
    logic [MAX_RGB_W-1:0] r;
    int cw;
    c24 = idx < 8 ? DEFAULT_PALETTE[idx[2:0]] : DEFAULT_PALETTE[COL_BG];
    cw = rgb_w / 3;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      v = MAX_RGB_W'(c24[ch*8 +: 8]);
      v = cw >= 8 ? v << (cw - 8) : v >> (8 - cw);
      r |= v << (ch * cw);
    end
    return r;
  endfunction
endpackage

// File: rtl/palette_bank_ram.sv
// palette_bank_ram: one palette bank, synchronous write, combinational read, reset to defaults.
module palette_bank_ram
  import vga_color_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int RGB_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [RGB_W-1:0] wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [RGB_W-1:0] rdata
);
  logic [RGB_W-1:0] mem [2**IDX_W];
  always_ff @(posedge clk)
    for (int i = 0; i < 2**IDX_W; i++)
      mem[i] <= rst ? RGB_W'(default_rgb(i, RGB_W)) : (we && widx == IDX_W'(i)) ? wdata : mem[i];
  assign rdata = mem[ridx];
endmodule

// File: rtl/palette_lut.sv
// palette_lut: multi-bank writable colour LUT, 2-cycle registered lookup, bank swap at frame start.
module palette_lut
  import vga_color_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int RGB_W = 24,
  parameter int BANKS = 2,
  parameter int BANK_W = BANKS > 1 ? $clog2(BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [RGB_W-1:0]  wr_rgb,
  input  logic [BANK_W-1:0] bank_req,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic              pix_de,
  input  logic [IDX_W-1:0]  pix_idx,
  output logic              rgb_valid,
  output logic [RGB_W-1:0]  rgb,
  output logic [BANK_W-1:0] bank_active,
  output logic              swap_pending
);
  logic [RGB_W-1:0] rd [BANKS];
  logic [RGB_W-1:0] s1_rgb;
  logic [BANK_W-1:0] bank_next;
  logic s1_valid;
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    palette_bank_ram #(.IDX_W(IDX_W), .RGB_W(RGB_W)) u_ram (
      .clk, .rst,
      .we(wr_en && wr_bank == BANK_W'(b)),
      .widx(wr_idx), .wdata(wr_rgb),
      .ridx(pix_idx), .rdata(rd[b])
    );
  end
  // The frame-start pixel already uses the requested bank; out-of-range requests are dropped.
  always_comb bank_next = frame_start && 32'(bank_req) < BANKS ? bank_req : bank_active;
  assign swap_pending = bank_req != bank_active;
  // Array read is captured in stage 1 so a same-cycle write still yields the old colour.
  always_ff @(posedge clk) begin
    bank_active <= rst ? '0 : bank_next;
    s1_valid <= rst ? 1'b0 : pix_valid;
    s1_rgb <= pix_de ? rd[bank_next] : '0;
    rgb_valid <= rst ? 1'b0 : s1_valid;
    rgb <= rst ? '0 : s1_valid ? s1_rgb : rgb;
  end
endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: table vectors, directed corner sequences and random traffic against a palette model.
module tb_palette_lut;
  localparam logic [23:0] DEF [8] = '{
    24'hAAAAAA, 24'h000000, 24'h00FFFF, 24'hFFE4B5,
    24'hD2B48C, 24'h00FF00, 24'hFFFFFF, 24'hAAAAAA
  };
  typedef struct {
    logic [2:0]  idx;
    logic        de;
    logic [23:0] exp;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  logic wr_en = 0;
  logic [1:0] wr_bank = 0;
  logic [2:0] wr_idx = 0;
  logic [23:0] wr_rgb = 0;
  logic [1:0] bank_req = 0;
  logic frame_start = 0;
  logic pix_valid = 0;
  logic pix_de = 0;
  logic [2:0] pix_idx = 0;
  logic rgb_valid;
  logic [23:0] rgb;
  logic [1:0] bank_active;
  logic swap_pending;
  int tests = 0;
  int fails = 0;
  logic [23:0] m_pal [3][8];
  logic [1:0] m_act;
  logic m_out_v, m_pend_v;
  logic [23:0] m_out_rgb, m_pend_rgb;
  vec_t vec [16];

  palette_lut #(.IDX_W(3), .RGB_W(24), .BANKS(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx),
    .wr_rgb(wr_rgb), .bank_req(bank_req), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_de(pix_de), .pix_idx(pix_idx),
    .rgb_valid(rgb_valid), .rgb(rgb), .bank_active(bank_active),
    .swap_pending(swap_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out_v = 0;
    m_out_rgb = 0;
    m_pend_v = 0;
    m_pend_rgb = 0;
    m_act = 0;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 8; i++) m_pal[b][i] = DEF[i];
  endtask

  // One clock: model predicts from pre-edge state, then every output is compared after the edge.
  task automatic tick();
    logic [1:0] eff;
    logic [23:0] col;
    logic nv;
    eff = (frame_start && bank_req < 3) ? bank_req : m_act;
    col = pix_de ? m_pal[eff][pix_idx] : 24'h0;
    nv = pix_valid;
    @(posedge clk);
    if (rst) m_reset();
    else begin
      m_out_v = m_pend_v;
      if (m_pend_v) m_out_rgb = m_pend_rgb;
      m_pend_v = nv;
      m_pend_rgb = col;
      if (wr_en && wr_bank < 3) m_pal[wr_bank][wr_idx] = wr_rgb;
      if (frame_start && bank_req < 3) m_act = bank_req;
    end
    #1;
    check("model rgb_valid", 32'(rgb_valid), 32'(m_out_v));
    check("model rgb", 32'(rgb), 32'(m_out_rgb));
    check("model bank_active", 32'(bank_active), 32'(m_act));
    check("model swap_pending", 32'(swap_pending), 32'(bank_req != m_act));
  endtask

  task automatic px(input logic [2:0] i, input logic de);
    pix_valid = 1;
    pix_idx = i;
    pix_de = de;
  endtask

  task automatic wr(input logic [1:0] b, input logic [2:0] i, input logic [23:0] d);
    wr_en = 1;
    wr_bank = b;
    wr_idx = i;
    wr_rgb = d;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vec[i] = '{idx: 3'(i), de: 1'b1, exp: DEF[i]};
      vec[i+8] = '{idx: 3'(i), de: 1'b0, exp: 24'h0};
    end
    m_reset();
    tick();
    tick();
    rst = 0;
    check("reset rgb", 32'(rgb), 32'h0);
    check("reset rgb_valid", 32'(rgb_valid), 32'h0);
    check("reset bank_active", 32'(bank_active), 32'h0);
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) px(vec[i].idx, vec[i].de);
      else pix_valid = 0;
      tick();
      if (i > 0) begin
        check("table rgb", 32'(rgb), 32'(vec[i-1].exp));
        check("table rgb_valid", 32'(rgb_valid), 32'h1);
      end
    end
    tick();
    check("invalid rgb_valid", 32'(rgb_valid), 32'h0);
    check("invalid rgb held", 32'(rgb), 32'h0);

    wr(2'd1, 3'd5, 24'h123456);
    tick();
    wr_en = 0;
    bank_req = 1;
    px(3'd5, 1);
    tick();
    check("pending swap", 32'(swap_pending), 32'h1);
    pix_valid = 0;
    tick();
    check("pre-swap idx5", 32'(rgb), 32'h00FF00);
    frame_start = 1;
    px(3'd5, 1);
    tick();
    frame_start = 0;
    pix_valid = 0;
    check("swap bank_active", 32'(bank_active), 32'h1);
    check("swap cleared pending", 32'(swap_pending), 32'h0);
    tick();
    check("swap frame pixel", 32'(rgb), 32'h123456);

    bank_req = 0;
    frame_start = 1;
    tick();
    frame_start = 0;
    wr(2'd0, 3'd2, 24'hFF0000);
    px(3'd2, 1);
    tick();
    wr_en = 0;
    px(3'd2, 1);
    tick();
    check("collision old", 32'(rgb), 32'h00FFFF);
    pix_valid = 0;
    tick();
    check("collision new", 32'(rgb), 32'hFF0000);

    bank_req = 3;
    frame_start = 1;
    tick();
    frame_start = 0;
    check("bad req bank_active", 32'(bank_active), 32'h0);
    check("bad req pending", 32'(swap_pending), 32'h1);
    bank_req = 0;
    wr(2'd3, 3'd0, 24'h111111);
    tick();
    wr_en = 0;
    px(3'd0, 1);
    tick();
    pix_valid = 0;
    tick();
    check("bad bank write", 32'(rgb), 32'hAAAAAA);

    for (int n = 0; n < 400; n++) begin
      pix_valid = ($urandom % 4) != 0;
      pix_de = ($urandom % 4) != 0;
      pix_idx = 3'($urandom);
      wr_en = ($urandom % 3) == 0;
      wr_bank = 2'($urandom);
      wr_idx = 3'($urandom);
      wr_rgb = 24'($urandom);
      frame_start = ($urandom % 12) == 0;
      if (($urandom % 8) == 0) bank_req = 2'($urandom);
      rst = ($urandom % 97) == 0;
      tick();
    end
    rst = 0;
    wr_en = 0;
    frame_start = 0;

    wr(2'd1, 3'd5, 24'hABCDEF);
    tick();
    wr_en = 0;
    bank_req = 1;
    frame_start = 1;
    px(3'd3, 1);
    tick();
    frame_start = 0;
    px(3'd4, 1);
    rst = 1;
    tick();
    rst = 0;
    check("mid reset rgb_valid", 32'(rgb_valid), 32'h0);
    check("mid reset bank_active", 32'(bank_active), 32'h0);
    pix_valid = 0;
    tick();
    check("mid reset stage flushed", 32'(rgb_valid), 32'h0);
    frame_start = 1;
    px(3'd5, 1);
    tick();
    frame_start = 0;
    pix_valid = 0;
    tick();
    check("reset restores bank1 idx5", 32'(rgb), 32'h00FF00);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/palette_lut.md
Name: palette_lut

Overview:
- Programmable, multi-bank colour look-up table.
- Translates an IDX_W-bit pixel colour index from the sprite/pixel generator into an RGB_W-bit colour for the VGA output stage.
- Supersedes the fixed 8-entry colour decoder: entries are writable at run time, several palettes are held, and the active palette swaps only at frame start (tear-free).
- Output is registered with fixed latency and blanked outside the active video area.

Parameters:
- IDX_W, 3: colour index width; each bank holds 2**IDX_W entries.
- RGB_W, 24: output colour width, packed {R,G,B}, equal thirds.
- BANKS, 2: number of palettes; BANKS >= 1, and BANKS == 1 makes the bank fields degenerate.
- BANK_W, $clog2(BANKS) with minimum 1: bank select width (derived).

Ports:
- clk, in, 1: system/pixel clock.
- rst, in, 1: synchronous, active-high reset.
- wr_en, in, 1: palette write strobe.
- wr_bank, in, BANK_W: bank to write.
- wr_idx, in, IDX_W: entry to write.
- wr_rgb, in, RGB_W: colour to write.
- bank_req, in, BANK_W: requested display bank, sampled continuously.
- frame_start, in, 1: one-cycle pulse at the first pixel of the frame.
- pix_valid, in, 1: pixel index valid this cycle.
- pix_de, in, 1: display enable (active video).
- pix_idx, in, IDX_W: pixel colour index.
- rgb_valid, out, 1: rgb carries a result.
- rgb, out, RGB_W: output colour.
- bank_active, out, BANK_W: bank currently used for lookups.
- swap_pending, out, 1: bank_req differs from bank_active.

Behaviour:
- Reset (rst=1 at clk edge):
  - rgb=0, rgb_valid=0, bank_active=0, pipeline valids cleared.
  - Every bank is loaded with the default table: idx0=AAAAAA, 1=000000, 2=00FFFF, 3=FFE4B5, 4=D2B48C, 5=00FF00, 6=FFFFFF, 7=AAAAAA.
  - Entries with idx>=8 (when IDX_W>3) are AAAAAA.
  - For RGB_W!=24, each default channel is the 8-bit value left-aligned, truncated or zero-padded.
  - Reset asserted mid-frame or mid-write discards in-flight pixels and any write in that cycle.
- Writes:
  - With wr_en=1, entry[wr_bank][wr_idx] takes wr_rgb at the clock edge.
  - wr_bank >= BANKS is ignored (no entry changes).
  - Writes to any bank, including the active one, are allowed at any time.
- Latency: exactly 2 cycles from pix_valid to rgb_valid.
  - Stage 1 registers idx, de, valid and the effective bank, and reads the array.
  - Stage 2 registers the colour.
- Read/write collision: a pixel sampled in the same cycle as a write to its entry returns the old colour. The new colour is visible to pixels sampled from the next cycle on.
- Blanking: if pix_de=0 for a valid pixel, rgb=0 with rgb_valid=1.
- Invalid pixels: if pix_valid=0, rgb_valid=0 two cycles later and rgb holds its previous value.
- Bank swap:
  - bank_active updates to bank_req only on a cycle with frame_start=1.
  - A pixel presented in the same cycle as frame_start already uses the new bank (effective bank = frame_start ? bank_req : bank_active).
  - bank_req >= BANKS at frame_start is ignored (bank_active unchanged).
- swap_pending is combinational: (bank_req != bank_active).
- Throughput: one pixel per cycle, no backpressure, no stalls.
- Index range: all index values are legal; there are no out-of-range indices.

Decomposition:
- Package vga_color_pkg holds:
  - the default palette constant array (8 x 24-bit);
  - localparam names for the default indices (COL_BG, COL_BLACK, COL_CYAN, COL_CREAM, COL_BROWN, COL_GREEN, COL_WHITE);
  - a function default_rgb(idx, RGB_W) used to build reset contents.
- One natural sub-module: palette_bank_ram. It is a single-bank register array with synchronous write and combinational read, instantiated BANKS times. The lookup pipeline and bank FSM stay in palette_lut.

Test Plan:
- Reset, then stream idx 0..7 with de=1 and valid=1 on bank 0 → rgb sequence AAAAAA, 000000, 00FFFF, FFE4B5, D2B48C, 00FF00, FFFFFF, AAAAAA, each 2 cycles after input.
- Same stream with de=0 → rgb=000000 and rgb_valid=1 for all eight. Then valid=0 → rgb_valid=0 after 2 cycles.
- Write bank1 idx5=123456, set bank_req=1 mid-frame:
  - swap_pending=1 and idx5 still gives 00FF00;
  - at frame_start with idx5 presented → 123456 two cycles later, bank_active=1, swap_pending=0.
- Write bank0 idx2=FF0000 in the same cycle pix_idx=2 → 00FFFF; next pixel idx2 → FF0000.
- With BANKS=3, bank_req=3 at frame_start → bank_active unchanged. wr_bank=3 write → no entry changes.
- Assert rst for one cycle during streaming, after prior writes → rgb_valid=0 next cycle, bank_active=0, all entries restored to defaults (idx5 in bank1 reads 00FF00).
